// File: rtl/wb_initiator.sv
// wb_initiator: single-outstanding Wishbone classic-cycle initiator.
// Accepts one request on req_*, runs one bus read or write on wbm_*, and returns
// the result on rsp_*. A per-transaction timeout aborts a cycle that is never acked.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   req_valid/req_ready        request handshake; req_we/addr/wdata/sel payload
//   rsp_valid/rsp_ready        response handshake; rsp_rdata, rsp_err (timeout)
//   wbm_cyc_o .. wbm_sel_o     Wishbone initiator outputs (stb mirrors cyc)
//   wbm_dat_i, wbm_ack_i       Wishbone slave read data and acknowledge
module wb_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned SEL_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                req_ready_d;
    logic                rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_d;
    logic                rsp_err_d;
    logic                cyc_d;
    logic                we_d;
    logic [ADDR_W-1:0]   adr_d;
    logic [DATA_W-1:0]   dat_d;
    logic [SEL_W-1:0]    sel_d;
    logic                timeout_c;

    // Timeout fires on the edge where the counter has seen TIMEOUT_CYCLES-1 unacked cycles.
    assign timeout_c = (TIMEOUT_CYCLES != 0) &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    assign wbm_stb_o = wbm_cyc_o;

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;
        we_d        = wbm_we_o;
        adr_d       = wbm_adr_o;
        dat_d       = wbm_dat_o;
        sel_d       = wbm_sel_o;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    we_d    = req_we;
                    adr_d   = req_addr;
                    dat_d   = req_wdata;
                    sel_d   = req_sel;
                    cnt_d   = '0;
                    state_d = BUS;
                end
            end
            BUS: begin
                // Ack has priority over a timeout on the same edge.
                if (wbm_ack_i) begin
                    rsp_rdata_d = wbm_we_o ? '0 : wbm_dat_i;
                    rsp_err_d   = 1'b0;
                    state_d     = RESP;
                end else if (timeout_c) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake and bus-cycle flags follow the state being entered.
        req_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
        cyc_d       = (state_d == BUS);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            wbm_cyc_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            wbm_sel_o <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
            wbm_cyc_o <= cyc_d;
            wbm_we_o  <= we_d;
            wbm_adr_o <= adr_d;
            wbm_dat_o <= dat_d;
            wbm_sel_o <= sel_d;
        end
    end

endmodule
